// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 key receiver.
// Define PS2_ASCII_EN to carry an ASCII translation with every event.
package ps2_pkg;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } ps2_state_e;

`ifdef PS2_ASCII_EN
    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
        logic [7:0] ascii;
    } ps2_event_t;

    // Set 2 make codes for A-Z and 0-9; everything else has no ASCII form.
    function automatic logic [7:0] ps2_ascii(input logic [7:0] code);
        case (code)
            8'h1C: return 8'h41;
            8'h32: return 8'h42;
            8'h21: return 8'h43;
            8'h23: return 8'h44;
            8'h24: return 8'h45;
            8'h2B: return 8'h46;
            8'h34: return 8'h47;
            8'h33: return 8'h48;
            8'h43: return 8'h49;
            8'h3B: return 8'h4A;
            8'h42: return 8'h4B;
            8'h4B: return 8'h4C;
            8'h3A: return 8'h4D;
            8'h31: return 8'h4E;
            8'h44: return 8'h4F;
            8'h4D: return 8'h50;
            8'h15: return 8'h51;
            8'h2D: return 8'h52;
            8'h1B: return 8'h53;
            8'h2C: return 8'h54;
            8'h3C: return 8'h55;
            8'h2A: return 8'h56;
            8'h1D: return 8'h57;
            8'h22: return 8'h58;
            8'h35: return 8'h59;
            8'h1A: return 8'h5A;
            8'h45: return 8'h30;
            8'h16: return 8'h31;
            8'h1E: return 8'h32;
            8'h26: return 8'h33;
            8'h25: return 8'h34;
            8'h2E: return 8'h35;
            8'h36: return 8'h36;
            8'h3D: return 8'h37;
            8'h3E: return 8'h38;
            8'h46: return 8'h39;
            default: return 8'h00;
        endcase
    endfunction
`else
    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_event_t;
`endif

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: pin synchronisers, clock glitch filter, 11-bit frame FSM
// and inactivity timeout. Emits a received byte with good/error strobes.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILT_LEN    = 4,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2k_clk,
    input  logic       ps2k_data,
    output logic [7:0] rx_byte,
    output logic       rx_good,
    output logic       err_parity,
    output logic       err_frame
);

    localparam int unsigned FW = $clog2(FILT_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [FW-1:0] FILT_MAX = FW'(FILT_LEN - 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYC - 1);

    logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic          filt_q, filt_d, filt_prev_q, fall;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;

    ps2_state_e    state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          good_q, good_d, perr_q, perr_d, ferr_q, ferr_d;

    // Lines idle high, so the synchronisers and filter reset to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1_q    <= 1'b1;
            clk_s2_q    <= 1'b1;
            dat_s1_q    <= 1'b1;
            dat_s2_q    <= 1'b1;
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
            filt_cnt_q  <= '0;
        end else begin
            clk_s1_q    <= ps2k_clk;
            clk_s2_q    <= clk_s1_q;
            dat_s1_q    <= ps2k_data;
            dat_s2_q    <= dat_s1_q;
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            filt_cnt_q  <= filt_cnt_d;
        end
    end

    // The filtered clock flips only after FILT_LEN consecutive opposing samples.
    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (clk_s2_q != filt_q) begin
            if (filt_cnt_q == FILT_MAX) begin
                filt_d = clk_s2_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
    end

    assign fall = filt_prev_q & ~filt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            par_q     <= 1'b0;
            tmo_q     <= '0;
            good_q    <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            par_q     <= par_d;
            tmo_q     <= tmo_d;
            good_q    <= good_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        par_d     = par_q;
        good_d    = 1'b0;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;

        if (state_q == StIdle || fall) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end

        if (fall) begin
            unique case (state_q)
                StIdle: begin
                    if (!dat_s2_q) begin
                        state_d   = StData;
                        bit_cnt_d = '0;
                        par_d     = 1'b0;
                    end
                end
                StData: begin
                    shreg_d   = {dat_s2_q, shreg_q[7:1]};
                    par_d     = par_q ^ dat_s2_q;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = StParity;
                    end
                end
                StParity: begin
                    par_d   = par_q ^ dat_s2_q;
                    state_d = StStop;
                end
                StStop: begin
                    state_d = StIdle;
                    // par_q holds the XOR of data and parity bits: 1 means odd.
                    if (!dat_s2_q) begin
                        ferr_d = 1'b1;
                    end else if (!par_q) begin
                        perr_d = 1'b1;
                    end else begin
                        good_d = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end else if (state_q != StIdle && tmo_q == TMO_MAX) begin
            state_d = StIdle;
            ferr_d  = 1'b1;
        end
    end

    assign rx_byte    = shreg_q;
    assign rx_good    = good_q;
    assign err_parity = perr_q;
    assign err_frame  = ferr_q;

endmodule

// File: rtl/ps2_key_fifo.sv
// PS/2 keyboard receiver with E0/F0 prefix folding and a first-word-fall-through
// event FIFO. Define PS2_ASCII_EN to add the ev_ascii output and scan-code ROM.
module ps2_key_fifo
    import ps2_pkg::*;
#(
    parameter int unsigned FILT_LEN    = 4,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ps2k_clk,
    input  logic                        ps2k_data,
    output logic                        ev_valid,
    input  logic                        ev_ready,
    output logic [7:0]                  ev_code,
    output logic                        ev_ext,
    output logic                        ev_brk,
`ifdef PS2_ASCII_EN
    output logic [7:0]                  ev_ascii,
`endif
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        err_parity,
    output logic                        err_frame,
    output logic                        ovf
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [7:0]    rx_byte;
    logic          rx_good, rx_perr, rx_ferr;

    ps2_event_t    mem [FIFO_DEPTH];
    ps2_event_t    new_ev, head;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          ext_q, ext_d, brk_q, brk_d, ovf_q, ovf_d;
    logic          push, push_ok, pop, full;

    ps2_frame_rx #(
        .FILT_LEN    (FILT_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_frame_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2k_clk   (ps2k_clk),
        .ps2k_data  (ps2k_data),
        .rx_byte    (rx_byte),
        .rx_good    (rx_good),
        .err_parity (rx_perr),
        .err_frame  (rx_ferr)
    );

    always_comb begin
        new_ev      = '0;
        new_ev.ext  = ext_q;
        new_ev.brk  = brk_q;
        new_ev.code = rx_byte;
`ifdef PS2_ASCII_EN
        // Extended keys never share ASCII with their unprefixed codes.
        new_ev.ascii = ext_q ? 8'h00 : ps2_ascii(rx_byte);
`endif
    end

    always_comb begin
        full    = (level_q == LW'(FIFO_DEPTH));
        pop     = (level_q != '0) && ev_ready;
        push    = rx_good && (rx_byte != PS2_PREFIX_EXT) && (rx_byte != PS2_PREFIX_BRK);
        push_ok = push && (!full || pop);
        ovf_d   = push && !push_ok;

        ext_d = ext_q;
        brk_d = brk_q;
        if (rx_perr || rx_ferr) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (rx_good) begin
            if (rx_byte == PS2_PREFIX_EXT) begin
                ext_d = 1'b1;
            end else if (rx_byte == PS2_PREFIX_BRK) begin
                brk_d = 1'b1;
            end else begin
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        level_d = level_q + LW'(push_ok) - LW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ext_q    <= 1'b0;
            brk_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ext_q    <= ext_d;
            brk_q    <= brk_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= new_ev;
        end
    end

    // Storage is not reset, so the head is masked while the FIFO is empty.
    assign head       = mem[rd_ptr_q];
    assign ev_valid   = (level_q != '0);
    assign ev_code    = ev_valid ? head.code : 8'h00;
    assign ev_ext     = ev_valid & head.ext;
    assign ev_brk     = ev_valid & head.brk;
`ifdef PS2_ASCII_EN
    assign ev_ascii   = ev_valid ? head.ascii : 8'h00;
`endif
    assign fifo_level = level_q;
    assign err_parity = rx_perr;
    assign err_frame  = rx_ferr;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_ps2_key_fifo.sv
// Directed and randomised bench for ps2_key_fifo with a queue-based event model.
// Build with PS2_ASCII_EN defined to also check ev_ascii.
module tb_ps2_key_fifo;

    localparam int unsigned FILT_LEN    = 4;
    localparam int unsigned FIFO_DEPTH  = 4;
    localparam int unsigned TIMEOUT_CYC = 300;
    localparam int unsigned HALF        = 10;

    logic                        clk = 1'b0;
    logic                        rst_n = 1'b0;
    logic                        ps2k_clk = 1'b1;
    logic                        ps2k_data = 1'b1;
    logic                        ev_ready = 1'b0;
    logic                        ev_valid, ev_ext, ev_brk;
    logic [7:0]                  ev_code;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;
    logic                        err_parity, err_frame, ovf;
`ifdef PS2_ASCII_EN
    logic [7:0]                  ev_ascii;
`endif

    ps2_key_fifo #(
        .FILT_LEN    (FILT_LEN),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2k_clk   (ps2k_clk),
        .ps2k_data  (ps2k_data),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_code    (ev_code),
        .ev_ext     (ev_ext),
        .ev_brk     (ev_brk),
`ifdef PS2_ASCII_EN
        .ev_ascii   (ev_ascii),
`endif
        .fifo_level (fifo_level),
        .err_parity (err_parity),
        .err_frame  (err_frame),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ev_t;

    int  total = 0;
    int  bad = 0;
    int  n_perr = 0, n_ferr = 0, n_ovf = 0;
    ev_t q[$];
    bit  m_ext = 0, m_brk = 0;
    int  exp_ovf = 0;

    always @(negedge clk) begin
        if (err_parity) n_perr <= n_perr + 1;
        if (err_frame)  n_ferr <= n_ferr + 1;
        if (ovf)        n_ovf  <= n_ovf + 1;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

`ifdef PS2_ASCII_EN
    function automatic logic [7:0] ref_ascii(input ev_t e);
        logic [7:0] letters [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                     8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                     8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                     8'h35, 8'h1A};
        logic [7:0] digits [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                    8'h3E, 8'h46};
        if (e.ext) return 8'h00;
        for (int i = 0; i < 26; i++) if (letters[i] == e.code) return 8'(8'h41 + i);
        for (int i = 0; i < 10; i++) if (digits[i] == e.code) return 8'(8'h30 + i);
        return 8'h00;
    endfunction
`endif

    // Reference: prefixes set flags; other bytes become events unless the FIFO is full.
    task automatic model_byte(input logic [7:0] b);
        ev_t e;
        if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else begin
            e.ext = m_ext; e.brk = m_brk; e.code = b;
            if (q.size() < FIFO_DEPTH) q.push_back(e);
            else exp_ovf++;
            m_ext = 0; m_brk = 0;
        end
    endtask

    task automatic model_err();
        m_ext = 0; m_brk = 0;
    endtask

    // Drives the first nbits of an 11-bit frame; bad_par flips the parity bit.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
        logic [10:0] f;
        logic        p;
        p = ~(^b) ^ bad_par;
        f = {1'b1, p, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk) ps2k_data = f[i];
            repeat (HALF) @(negedge clk);
            ps2k_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2k_clk = 1'b1;
        end
        @(negedge clk) ps2k_data = 1'b1;
        repeat (3 * HALF) @(negedge clk);
    endtask

    task automatic send_good(input logic [7:0] b);
        send_frame(b, 1'b0, 11);
        model_byte(b);
    endtask

    task automatic drain_check(input string tag);
        ev_t e;
        int  t;
        while (q.size() > 0) begin
            e = q.pop_front();
            t = 0;
            while (!ev_valid && t < 50) begin
                @(negedge clk);
                t++;
            end
            check({tag, ".valid"}, 32'(ev_valid), 32'd1);
            check({tag, ".code"}, 32'(ev_code), 32'(e.code));
            check({tag, ".ext"}, 32'(ev_ext), 32'(e.ext));
            check({tag, ".brk"}, 32'(ev_brk), 32'(e.brk));
`ifdef PS2_ASCII_EN
            check({tag, ".ascii"}, 32'(ev_ascii), 32'(ref_ascii(e)));
`endif
            ev_ready = 1'b1;
            @(negedge clk);
            ev_ready = 1'b0;
            @(negedge clk);
        end
        check({tag, ".empty"}, 32'(ev_valid), 32'd0);
        check({tag, ".level0"}, 32'(fifo_level), 32'd0);
    endtask

    initial begin
        int snap_p, snap_f, snap_o, snap_x, n, r;
        logic [7:0] b;

        // Reset values
        repeat (5) @(negedge clk);
        check("rst.valid", 32'(ev_valid), 32'd0);
        check("rst.code", 32'(ev_code), 32'd0);
        check("rst.ext", 32'(ev_ext), 32'd0);
        check("rst.brk", 32'(ev_brk), 32'd0);
        check("rst.level", 32'(fifo_level), 32'd0);
        check("rst.err", 32'({err_parity, err_frame, ovf}), 32'd0);
`ifdef PS2_ASCII_EN
        check("rst.ascii", 32'(ev_ascii), 32'd0);
`endif
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Single make code held in the FIFO
        send_good(8'h1C);
        check("t1.level", 32'(fifo_level), 32'd1);
        drain_check("t1");

        // Extended break then plain make
        send_good(8'hE0);
        send_good(8'hF0);
        send_good(8'h75);
        send_good(8'h75);
        check("t2.level", 32'(fifo_level), 32'd2);
        drain_check("t2");

        // Parity error drops the byte
        snap_p = n_perr;
        send_good(8'hF0);
        send_frame(8'h1C, 1'b1, 11);
        model_err();
        check("t3.perr", 32'(n_perr - snap_p), 32'd1);
        check("t3.level", 32'(fifo_level), 32'd0);
        send_good(8'h32);
        drain_check("t3");

        // Timeout after four data bits
        snap_f = n_ferr;
        send_frame(8'h21, 1'b0, 5);
        model_err();
        repeat (TIMEOUT_CYC + 50) @(negedge clk);
        check("t4.ferr", 32'(n_ferr - snap_f), 32'd1);
        send_good(8'h21);
        drain_check("t4");

        // Overflow
        snap_o = n_ovf;
        for (int i = 0; i <= FIFO_DEPTH; i++) send_good(8'(8'h10 + i));
        check("t5.level", 32'(fifo_level), 32'(FIFO_DEPTH));
        check("t5.ovf", 32'(n_ovf - snap_o), 32'd1);
        drain_check("t5");

        // Random frames with occasional prefixes and parity faults
        for (int round = 0; round < 4; round++) begin
            snap_o = n_ovf;
            snap_x = exp_ovf;
            n = $urandom_range(FIFO_DEPTH + 2, 1);
            for (int k = 0; k < n; k++) begin
                r = $urandom_range(9, 0);
                b = 8'($urandom_range(255, 0));
                if (r == 0) send_good(8'hE0);
                else if (r == 1) send_good(8'hF0);
                else if (r == 2) begin
                    send_frame(b, 1'b1, 11);
                    model_err();
                end else send_good(b);
            end
            check("rnd.level", 32'(fifo_level), 32'(q.size()));
            check("rnd.ovf", 32'(n_ovf - snap_o), 32'(exp_ovf - snap_x));
            drain_check("rnd");
        end

        // One-cycle clock glitches with data low must not start a frame
        snap_p = n_perr;
        snap_f = n_ferr;
        @(negedge clk) ps2k_data = 1'b0;
        for (int g = 0; g < 10; g++) begin
            @(negedge clk) ps2k_clk = 1'b0;
            @(negedge clk) ps2k_clk = 1'b1;
            repeat (5) @(negedge clk);
        end
        ps2k_data = 1'b1;
        repeat (TIMEOUT_CYC + 50) @(negedge clk);
        check("glitch.err", 32'((n_perr - snap_p) + (n_ferr - snap_f)), 32'd0);
        check("glitch.level", 32'(fifo_level), 32'd0);

        // Reset in the middle of a frame with one event queued
        send_good(8'h45);
        send_frame(8'h16, 1'b0, 6);
        rst_n = 1'b0;
        q.delete();
        model_err();
        repeat (3) @(negedge clk);
        check("mrst.valid", 32'(ev_valid), 32'd0);
        check("mrst.code", 32'(ev_code), 32'd0);
        check("mrst.level", 32'(fifo_level), 32'd0);
        check("mrst.err", 32'({err_parity, err_frame, ovf}), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        send_good(8'h16);
        check("mrst.level1", 32'(fifo_level), 32'd1);
        drain_check("mrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_key_fifo.md
# ps2_key_fifo

Parametrised PS/2 keyboard receiver that replaces the single-byte scanner in the keyboard-to-UART and seven-segment path. It filters the keyboard clock, captures and checks 11-bit frames, and folds `E0`/`F0` prefixes into complete key events. Events are buffered in a FIFO with a valid/ready handshake, so a slow consumer such as the UART transmitter loses no keystrokes. Sits between the `ps2k_clk`/`ps2k_data` pins and any consumer: the UART, the display, or a CPU register.

## Interface
- `FILT_LEN`, 4: number of consecutive equal samples required before the filtered PS/2 clock changes state (range 2–16).
- `FIFO_DEPTH`, 16: event FIFO depth in entries; must be a power of 2, range 2–256.
- `TIMEOUT_CYC`, 50000: `clk` cycles without a falling edge before a partial frame is aborted.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `ps2k_clk`  in  1  PS/2 clock pin, asynchronous.
- `ps2k_data`  in  1  PS/2 data pin, asynchronous.
- `ev_valid`  out  1  FIFO non-empty.
- `ev_ready`  in  1  consumer accepts the head entry.
- `ev_code`  out  8  scan code of the head event.
- `ev_ext`  out  1  head event was preceded by `E0`.
- `ev_brk`  out  1  head event is a break (preceded by `F0`).
- `ev_ascii`  out  8  ASCII of the head event; present only with `PS2_ASCII_EN`.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current entry count.
- `err_parity`  out  1  one-cycle pulse on a parity failure.
- `err_frame`  out  1  one-cycle pulse on a bad stop bit or a timeout.
- `ovf`  out  1  one-cycle pulse when an event is dropped because the FIFO is full.

## Operation
- Synchronisation:
  - Both pins pass through 2-flop synchronisers.
  - The clock additionally passes through the `FILT_LEN` filter.
  - A falling edge of the filtered clock samples the synchronised data.
- Frame FSM states: IDLE, DATA (8 bits, LSB first), PARITY, STOP.
  - IDLE: an edge with data=1 is ignored and the FSM stays in IDLE. Data=0 moves to DATA.
  - STOP: data=1 with odd parity over data+parity bits means the byte is good.
  - Parity bad: pulse `err_parity` and discard the byte.
  - Stop bit 0: pulse `err_frame` and discard the byte.
- Timeout: in any state other than IDLE, the counter reaches `TIMEOUT_CYC` → return to IDLE and pulse `err_frame`.
- Prefix decoder, on each good byte:
  - `E0` sets ext.
  - `F0` sets brk.
  - Any other byte pushes {ext, brk, byte}, then clears both flags.
  - A discarded byte, or any frame or parity error, also clears both flags.
- FIFO is first-word-fall-through:
  - `ev_*` outputs reflect the head entry whenever `ev_valid`=1.
  - A pop occurs on `ev_valid & ev_ready`.
- Full-FIFO boundaries:
  - Push while full without a pop → event dropped, `ovf` pulse, flags cleared.
  - Push and pop in the same cycle while full → both performed; level unchanged.
- Pointers wrap modulo `FIFO_DEPTH`.

## Timing
- Reset values:
  - `ev_valid`, `ev_code`, `ev_ext`, `ev_brk`, `ev_ascii`, `err_*` and `ovf` = 0.
  - `fifo_level` = 0.
  - FSM in IDLE, flags clear.
  - Reset mid-frame discards the partial frame and all FIFO contents.
- Filter delay: 2 cycles of synchronisation plus `FILT_LEN` cycles from a pin edge to the filtered edge.
- Good-byte strobe: the cycle after the filtered falling edge of the stop bit.
- FIFO push and prefix-flag update: the cycle after the strobe.
- `ev_valid` rises the cycle after the push edge.
- Error and `ovf` pulses are exactly 1 cycle wide and are registered.
- `fifo_level` updates the cycle after a push or pop.

## Configuration
- `PS2_ASCII_EN` defined:
  - Adds the `ev_ascii` port and a 256-entry scan-code ROM stored alongside each FIFO entry.
  - Mapping is Set 2 codes for A–Z (e.g. `1C`→`41`, `32`→`42`, `21`→`43`, `1A`→`5A`) and 0–9 (`45`→`30`, `16`→`31`).
  - All other codes map to `00`. Entries with ext=1 map to `00`.
  - Make and break events carry the same ASCII value.
- Not defined: no `ev_ascii` port, no ROM, and the FIFO entry width is 10 bits.

## Structure
- Package `ps2_pkg` holds:
  - `PS2_PREFIX_EXT`=8'hE0 and `PS2_PREFIX_BRK`=8'hF0.
  - Frame FSM state enum.
  - `ps2_event_t` struct {ext, brk, code[7:0]}, extended with ascii[7:0] when `PS2_ASCII_EN` is defined.
- Sub-module `ps2_frame_rx` contains the synchronisers, filter, frame FSM and timeout. It outputs a byte, a byte-good strobe and error strobes.
- Prefix decode, FIFO and ROM live in the top module.

## Test plan
- Frame `1C` with `ev_ready`=0 → one entry {ext=0, brk=0, code=1C}; `fifo_level`=1; `ev_ascii`=41 when `PS2_ASCII_EN` is defined.
- Sequence `E0 F0 75` → exactly one entry {ext=1, brk=1, code=75}; a following plain `75` → {0, 0, 75}.
- Frame `1C` sent with even parity → `err_parity` pulses once; no entry; a following valid `32` → {0, 0, 32}.
- Keyboard clock stopped after 4 data bits for more than `TIMEOUT_CYC` cycles → `err_frame` pulses once; the next full frame `21` is received correctly.
- `FIFO_DEPTH`+1 frames with `ev_ready`=0 → `fifo_level`=`FIFO_DEPTH`; `ovf` pulses once; drain yields the first `FIFO_DEPTH` codes in order.
- 1-cycle glitches on `ps2k_clk`, with `FILT_LEN`=4 → no frame activity; assert `rst_n` mid-frame → all outputs return to 0 and the next frame is decoded cleanly.
